// File: rtl/plic_irq_router_if.sv
// Interrupt-side signal bundle between the source fabric and the PLIC router.
// The slave modport is the router's view; the master modport is the fabric/PLIC view.
interface plic_irq_router_if #(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned NUM_PLIC = 32
);
  logic [NUM_SRC-1:0]  src_irq_i;
  logic [NUM_SRC-1:0]  src_enable_i;
  logic [NUM_PLIC-1:0] plic_clear_i;
  logic [NUM_PLIC-1:0] plic_irq_o;
  logic [NUM_SRC-1:0]  src_pending_o;
  logic [NUM_SRC-1:0]  src_overflow_o;

  modport slave (
    input  src_irq_i,
    input  src_enable_i,
    input  plic_clear_i,
    output plic_irq_o,
    output src_pending_o,
    output src_overflow_o
  );

  modport master (
    output src_irq_i,
    output src_enable_i,
    output plic_clear_i,
    input  plic_irq_o,
    input  src_pending_o,
    input  src_overflow_o
  );
endinterface

// File: rtl/plic_irq_router.sv
// Routes synchronised level or edge-captured interrupt sources onto PLIC lines via an
// elaboration-time map, with per-source pending latch and sticky overflow for edge sources.
module plic_irq_router #(
  parameter int unsigned          NUM_SRC     = 4,
  parameter int unsigned          NUM_PLIC    = 32,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [NUM_SRC*8-1:0] SRC_MAP     = {8'd4, 8'd3, 8'd2, 8'd1},
  parameter logic [NUM_SRC-1:0]   EDGE_MASK   = '0
) (
  input logic               clock_i,
  input logic               reset_ni,
  plic_irq_router_if.slave  bus_io
);

  if (NUM_SRC == 0 || NUM_SRC > 31) begin : g_bad_num_src
    $fatal(1, "plic_irq_router: NUM_SRC must be 1..31");
  end
  if (SYNC_STAGES == 0) begin : g_bad_sync
    $fatal(1, "plic_irq_router: SYNC_STAGES must be at least 1");
  end
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_map_chk
    if (SRC_MAP[gi*8 +: 8] == 8'd0 || int'(SRC_MAP[gi*8 +: 8]) >= int'(NUM_PLIC)) begin : g_bad
      $fatal(1, "plic_irq_router: SRC_MAP entry %0d out of range 1..NUM_PLIC-1", gi);
    end
  end

  logic [NUM_SRC-1:0]  r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0]  r_prev;
  logic [NUM_SRC-1:0]  r_pend;
  logic [NUM_SRC-1:0]  r_ovf;
  logic [NUM_PLIC-1:0] r_irq;

  logic [NUM_SRC-1:0]  w_sync;
  logic [NUM_SRC-1:0]  w_rise;
  logic [NUM_SRC-1:0]  w_clr;
  logic [NUM_SRC-1:0]  w_contrib;
  logic [NUM_PLIC-1:0] w_irq_d;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= bus_io.src_irq_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_sync & ~r_prev & bus_io.src_enable_i;
  assign w_contrib = (EDGE_MASK & r_pend) | (~EDGE_MASK & w_sync & bus_io.src_enable_i);

  // Line 0 is never visited, so it stays 0 and its clear bit is ignored.
  always_comb begin
    w_clr   = '0;
    w_irq_d = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int l = 1; l < NUM_PLIC; l++) begin
        if (int'(SRC_MAP[s*8 +: 8]) == l) begin
          w_clr[s]   = w_clr[s] | bus_io.plic_clear_i[l];
          w_irq_d[l] = w_irq_d[l] | w_contrib[s];
        end
      end
    end
  end

  // Set beats clear on collision; level sources keep no edge state.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_prev <= '0;
      r_pend <= '0;
      r_ovf  <= '0;
      r_irq  <= '0;
    end else begin
      r_prev <= w_sync;
      r_pend <= EDGE_MASK & (w_rise | (r_pend & ~w_clr));
      r_ovf  <= EDGE_MASK & ((w_rise & r_pend) | (r_ovf & ~w_clr));
      r_irq  <= w_irq_d;
    end
  end

  assign bus_io.plic_irq_o     = r_irq;
  assign bus_io.src_pending_o  = (EDGE_MASK & r_pend) | (~EDGE_MASK & w_sync);
  assign bus_io.src_overflow_o = r_ovf;

endmodule
